// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - sequential turn/hazard/brake tail-light controller
//
// Purpose: drives LAMPS lamps per side. A turn request lights its side as a
// growing bar (one more lamp per step, then all off), hazard blinks both sides,
// and brake lights any side that is not busy with a turn indication.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   left     - left-turn request (level)
//   right    - right-turn request (level)
//   hazard   - hazard request (level)
//   brake    - brake pedal (level), used one cycle late
//   l_lamps  - left lamps, bit 0 innermost
//   r_lamps  - right lamps, bit 0 innermost
//   mode     - current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ

module taillight_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] l_lamps,
    output logic [LAMPS-1:0] r_lamps,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    localparam int SW = $clog2(LAMPS + 1);
    // A one-bit prescaler is kept even for TICK_DIV = 1; it simply never leaves 0.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

    mode_t          mode_q;
    mode_t          mode_d;
    mode_t          req;
    logic [SW-1:0]  step_q;
    logic [SW-1:0]  step_d;
    logic [PW-1:0]  pre_q;
    logic [PW-1:0]  pre_d;
    logic           brake_q;
    logic           tick;
    logic [LAMPS-1:0] bar;

    // Hazard wins, and both turn requests together also mean hazard.
    always_comb begin
        req = IDLE;
        if (hazard || (left && right)) begin
            req = HAZ;
        end else if (left) begin
            req = LEFT;
        end else if (right) begin
            req = RIGHT;
        end
    end

    assign tick = (pre_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= IDLE;
            step_q  <= '0;
            pre_q   <= '0;
            brake_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            pre_q   <= pre_d;
            brake_q <= brake;
        end
    end

    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        if (req != mode_q) begin
            // A new request restarts the pattern from its dark phase.
            mode_d = req;
            step_d = '0;
            pre_d  = '0;
        end else if (tick) begin
            case (mode_q)
                LEFT, RIGHT: step_d = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
                HAZ:         step_d = (step_q == '0) ? STEP_MAX : '0;
                IDLE:        step_d = '0;
            endcase
        end
    end

    // Thermometer bar: lamps below the step index are lit.
    always_comb begin
        bar = '0;
        for (int i = 0; i < LAMPS; i++) begin
            bar[i] = (SW'(i) < step_q);
        end
    end

    always_comb begin
        l_lamps = '0;
        r_lamps = '0;
        case (mode_q)
            IDLE: begin
                l_lamps = brake_q ? '1 : '0;
                r_lamps = brake_q ? '1 : '0;
            end
            LEFT: begin
                l_lamps = bar;
                r_lamps = brake_q ? '1 : '0;
            end
            RIGHT: begin
                l_lamps = brake_q ? '1 : '0;
                r_lamps = bar;
            end
            HAZ: begin
                l_lamps = (step_q == STEP_MAX) ? '1 : '0;
                r_lamps = (step_q == STEP_MAX) ? '1 : '0;
            end
        endcase
    end

    assign mode = mode_q;

endmodule
